saradc_sar_ctrl: RTL and testbench

Synchronous successive-approximation controller for the SAR ADC. It drives the sampling switch, the binary-weighted DAC trial code and the comparator strobe into the analog cell array. It resolves one bit per two clock cycles from the comparator decision. Finished codes go out through a one-entry valid/ready output register to the digital consumer.

---
 rtl/saradc_sar_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_saradc_sar_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saradc_sar_ctrl.sv
// -----------------------------------------------------------------------------
// saradc_sar_ctrl
//
// Successive-approximation controller for the SAR ADC. A START request seen in
// IDLE samples the input for SAMPLE_CYCLES cycles. The controller then resolves
// one bit per SET/STB cycle pair, MSB first. The finished code is handed to the
// consumer through a one-entry valid/ready output register.
//
// Ports
//   CLK     in   sole clock, rising edge
//   RST     in   synchronous active-high reset; aborts any conversion and
//                drops a pending result
//   START   in   conversion request, only honoured in IDLE
//   CMP     in   comparator decision (1: Vin >= DAC), used only in STB cycles
//   SAMPLE  out  sampling switch enable
//   DAC     out  [NBITS] trial code for the DAC buffers
//   CMP_EN  out  comparator strobe
//   BUSY    out  high whenever the controller is not in IDLE
//   DOUT    out  [NBITS] converted code, frozen while VALID && !READY
//   VALID   out  DOUT holds an unconsumed result
//   READY   in   consumer accepts DOUT
// -----------------------------------------------------------------------------
module saradc_sar_ctrl #(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CMP,
    output logic             SAMPLE,
    output logic [NBITS-1:0] DAC,
    output logic             CMP_EN,
    output logic             BUSY,
    output logic [NBITS-1:0] DOUT,
    output logic             VALID,
    input  logic             READY
);

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SMP  = 3'd1,
        ST_SET  = 3'd2,
        ST_STB  = 3'd3,
        ST_LOAD = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NBITS-1:0] code_q, code_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             sample_q, sample_d;
    logic [NBITS-1:0] dac_q, dac_d;
    logic             cmp_en_q, cmp_en_d;
    logic             busy_q, busy_d;

    // One-hot weight of the bit that is being tried in the upcoming SET cycle.
    logic [NBITS-1:0] trial_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_trial_mask
            assign trial_mask[gi] = (idx_d == IW'(gi));
        end
    endgenerate

    // State register: every output is a flop, so the output process below
    // computes the value each output should hold in the *next* state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            idx_q    <= IW'(NBITS - 1);
            cnt_q    <= 4'd0;
            code_q   <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            sample_q <= 1'b0;
            dac_q    <= '0;
            cmp_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            dac_q    <= dac_d;
            cmp_en_q <= cmp_en_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic, including the decided code and the output slot.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        dout_d  = dout_q;
        valid_d = valid_q;

        // A transfer empties the slot; a load on the same edge refills it below.
        if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SMP;
                    code_d  = '0;
                    idx_d   = IW'(NBITS - 1);
                    cnt_d   = 4'(SAMPLE_CYCLES - 1);
                end
            end
            ST_SMP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SET;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SET: begin
                state_d = ST_STB;
            end
            ST_STB: begin
                code_d[idx_q] = CMP;
                if (idx_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = ST_SET;
                end
            end
            ST_LOAD: begin
                if (!valid_q || READY) begin
                    dout_d  = code_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic, decoded from the state being entered.
    always_comb begin
        sample_d = 1'b0;
        dac_d    = '0;
        cmp_en_d = 1'b0;
        busy_d   = (state_d != ST_IDLE);

        case (state_d)
            ST_SMP: begin
                sample_d = 1'b1;
            end
            ST_SET: begin
                dac_d = code_d | trial_mask;
            end
            ST_STB: begin
                // Hold the trial code so the DAC has settled before the strobe.
                dac_d    = dac_q;
                cmp_en_d = 1'b1;
            end
            ST_LOAD: begin
                dac_d = code_d;
            end
            default: begin
            end
        endcase
    end

    assign SAMPLE = sample_q;
    assign DAC    = dac_q;
    assign CMP_EN = cmp_en_q;
    assign BUSY   = busy_q;
    assign DOUT   = dout_q;
    assign VALID  = valid_q;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// -----------------------------------------------------------------------------
// tb_saradc_sar_ctrl
//
// Two controller instances share one clock and one reset. dut8 uses the
// default parameters, and dut10 uses NBITS=10 and SAMPLE_CYCLES=4. Each
// comparator is an ideal model: CMP = (Vin >= DAC). For the extreme-code
// scenario, the dut8 comparator can instead be tied to a constant.
//
// Expected values come from the conversion timeline. A conversion started at
// edge k occupies SAMPLE for SC edges and then N SET/STB pairs. It has one LOAD
// cycle and then returns to idle. The trial code for bit b keeps the bits of Vin
// above b and sets bit b.
// -----------------------------------------------------------------------------
module tb_saradc_sar_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start8, ready8, cmp8, sample8, cmp_en8, busy8, valid8;
    logic [7:0] dac8, dout8, vin8;
    logic       tie_en, tie_val;

    logic       start10, ready10, cmp10, sample10, cmp_en10, busy10, valid10;
    logic [9:0] dac10, dout10, vin10;

    assign cmp8  = tie_en ? tie_val : (vin8 >= dac8);
    assign cmp10 = (vin10 >= dac10);

    saradc_sar_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2)) dut8 (
        .CLK(clk), .RST(rst), .START(start8), .CMP(cmp8),
        .SAMPLE(sample8), .DAC(dac8), .CMP_EN(cmp_en8), .BUSY(busy8),
        .DOUT(dout8), .VALID(valid8), .READY(ready8)
    );

    saradc_sar_ctrl #(.NBITS(10), .SAMPLE_CYCLES(4)) dut10 (
        .CLK(clk), .RST(rst), .START(start10), .CMP(cmp10),
        .SAMPLE(sample10), .DAC(dac10), .CMP_EN(cmp_en10), .BUSY(busy10),
        .DOUT(dout10), .VALID(valid10), .READY(ready10)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected {SAMPLE, CMP_EN, BUSY, DAC} after edge k+j of an undisturbed
    // conversion started at edge k with a free output slot.
    function automatic logic [18:0] exp_obs(input int j, input int vin,
                                            input int n, input int sc);
        int   p;
        int   b;
        int   trial;
        logic s, c, bz;
        s  = 1'b0;
        c  = 1'b0;
        bz = 1'b0;
        trial = 0;
        if (j < sc) begin
            s  = 1'b1;
            bz = 1'b1;
        end else if (j < sc + 2 * n) begin
            p     = j - sc;
            b     = n - 1 - p / 2;
            trial = ((vin >> (b + 1)) << (b + 1)) | (1 << b);
            c     = (p % 2) == 1;
            bz    = 1'b1;
        end else if (j == sc + 2 * n) begin
            trial = vin;
            bz    = 1'b1;
        end
        return {s, c, bz, 16'(trial)};
    endfunction

    function automatic logic [18:0] obs8();
        return {sample8, cmp_en8, busy8, 8'h00, dac8};
    endfunction

    function automatic logic [18:0] obs10();
        return {sample10, cmp_en10, busy10, 6'h00, dac10};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({sample8, dac8, cmp_en8, busy8, dout8, valid8} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset8: outputs=%h required 0",
                     {sample8, dac8, cmp_en8, busy8, dout8, valid8});
        end
        n_checks++;
        if ({sample10, dac10, cmp_en10, busy10, dout10, valid10} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset10: outputs=%h required 0",
                     {sample10, dac10, cmp_en10, busy10, dout10, valid10});
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs checked at zero");
    endtask

    task automatic test_basic;
        vin8   = 8'hA5;
        ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int j = 0; j <= 21; j++) begin
            if (j > 0) tick();
            n_checks++;
            if (obs8() !== exp_obs(j, 32'hA5, 8, 2)) begin
                n_fail++;
                $display("FAIL basic_timeline edge %0d: {smp,cen,busy,dac}=%h required %h",
                         j, obs8(), exp_obs(j, 32'hA5, 8, 2));
            end
            n_checks++;
            if (valid8 !== (j == 19)) begin
                n_fail++;
                $display("FAIL basic_valid edge %0d: VALID=%b required %b", j, valid8, (j == 19));
            end
            if (j == 19) begin
                n_checks++;
                if (dout8 !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL basic_dout: DOUT=%h required a5", dout8);
                end
            end
        end
        $display("basic: Vin=a5 conversion, DOUT=%h", dout8);
    endtask

    task automatic test_extremes;
        logic [7:0] got;
        logic [7:0] last_trial;
        int         nsmp;
        ready8 = 1'b1;
        tie_en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tie_val    = (t == 0);
            got        = 8'h5A;
            last_trial = 8'h5A;
            nsmp       = 0;
            start8     = 1'b1;
            tick();
            start8 = 1'b0;
            for (int j = 0; j <= 21; j++) begin
                if (j > 0) tick();
                if (sample8) nsmp++;
                if (cmp_en8) last_trial = dac8;
                if (valid8) got = dout8;
            end
            n_checks++;
            if (nsmp != 2) begin
                n_fail++;
                $display("FAIL extreme_sample cmp=%0d: SAMPLE cycles=%0d required 2", tie_val, nsmp);
            end
            n_checks++;
            if (got !== (t == 0 ? 8'hFF : 8'h00)) begin
                n_fail++;
                $display("FAIL extreme_dout cmp=%0d: DOUT=%h required %h",
                         tie_val, got, (t == 0 ? 8'hFF : 8'h00));
            end
            if (t == 1) begin
                n_checks++;
                if (last_trial !== 8'h01) begin
                    n_fail++;
                    $display("FAIL extreme_last_dac: DAC=%h required 01", last_trial);
                end
            end
            $display("extremes: CMP tied %0d, DOUT=%h SAMPLE cycles=%0d", tie_val, got, nsmp);
        end
        tie_en = 1'b0;
    endtask

    task automatic test_backpressure;
        int n;
        ready8 = 1'b0;
        vin8   = 8'h3C;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!valid8 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (!valid8 || dout8 !== 8'h3C) begin
            n_fail++;
            $display("FAIL bp_first: VALID=%b DOUT=%h required 1/3c", valid8, dout8);
        end
        vin8   = 8'h81;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int j = 0; j < 30; j++) tick();
        n_checks++;
        if ({busy8, dac8, valid8, dout8} !== {1'b1, 8'h81, 1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL bp_stall: BUSY=%b DAC=%h VALID=%b DOUT=%h required 1/81/1/3c",
                     busy8, dac8, valid8, dout8);
        end
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        n_checks++;
        if ({valid8, dout8, busy8} !== {1'b1, 8'h81, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_swap: VALID=%b DOUT=%h BUSY=%b required 1/81/0", valid8, dout8, busy8);
        end
        tick();
        n_checks++;
        if ({valid8, dout8} !== {1'b1, 8'h81}) begin
            n_fail++;
            $display("FAIL bp_hold: VALID=%b DOUT=%h required 1/81", valid8, dout8);
        end
        ready8 = 1'b1;
        tick();
        n_checks++;
        if (valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: VALID=%b required 0", valid8);
        end
        $display("backpressure: 3c then 81 delivered in order");
    endtask

    task automatic test_start_while_busy;
        logic [7:0] v1;
        logic [7:0] v2;
        logic       prev_v;
        logic       exp_busy;
        int         rises;
        v1     = 8'($urandom_range(0, 255));
        v2     = 8'($urandom_range(0, 255));
        vin8   = v1;
        ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        prev_v = valid8;
        rises  = 0;
        for (int j = 1; j <= 40; j++) begin
            start8 = (j == 3 || j == 10 || j == 18 || j == 20);
            if (j == 20) vin8 = v2;
            tick();
            start8 = 1'b0;
            if (valid8 && !prev_v) rises++;
            prev_v   = valid8;
            exp_busy = (j < 19) || (j >= 20 && j < 39);
            n_checks++;
            if (busy8 !== exp_busy) begin
                n_fail++;
                $display("FAIL busy_start edge %0d: BUSY=%b required %b", j, busy8, exp_busy);
            end
            if (j == 19 || j == 39) begin
                n_checks++;
                if (!valid8 || dout8 !== (j == 19 ? v1 : v2)) begin
                    n_fail++;
                    $display("FAIL busy_result edge %0d: VALID=%b DOUT=%h required 1/%h",
                             j, valid8, dout8, (j == 19 ? v1 : v2));
                end
            end
        end
        n_checks++;
        if (rises != 2) begin
            n_fail++;
            $display("FAIL busy_pulses: VALID pulses=%0d required 2", rises);
        end
        $display("start_while_busy: %0d VALID pulses for two accepted STARTs", rises);
    endtask

    task automatic test_reset_mid;
        ready8 = 1'b1;
        vin8   = 8'($urandom_range(0, 255));
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int j = 1; j <= 9; j++) tick();
        n_checks++;
        if (cmp_en8 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_stb: CMP_EN=%b required 1", cmp_en8);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({sample8, dac8, cmp_en8, busy8, dout8, valid8} !== 19'h0) begin
            n_fail++;
            $display("FAIL rstmid_zero: outputs=%h required 0",
                     {sample8, dac8, cmp_en8, busy8, dout8, valid8});
        end
        for (int j = 0; j < 30; j++) begin
            tick();
            n_checks++;
            if (valid8 !== 1'b0 || busy8 !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_idle cycle %0d: VALID=%b BUSY=%b required 0/0", j, valid8, busy8);
            end
        end
        $display("reset_mid: conversion aborted at bit 4 strobe");
    endtask

    task automatic test_reset_valid;
        int n;
        ready8 = 1'b0;
        vin8   = 8'($urandom_range(1, 255));
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!valid8 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (valid8 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstvalid_pending: VALID=%b required 1", valid8);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({valid8, dout8} !== 9'h0) begin
            n_fail++;
            $display("FAIL rstvalid_clear: VALID=%b DOUT=%h required 0/00", valid8, dout8);
        end
        ready8 = 1'b1;
        $display("reset_valid: pending result dropped");
    endtask

    task automatic test_sweep;
        logic [9:0] sb[$];
        logic [9:0] held;
        logic [9:0] want;
        logic       hold;
        int         lat;
        int         launched;
        int         received;
        int         cyc;

        ready10 = 1'b1;
        vin10   = 10'($urandom_range(0, 1023));
        start10 = 1'b1;
        tick();
        start10 = 1'b0;
        lat = 0;
        while (!valid10 && lat < 60) begin
            tick();
            lat++;
            n_checks++;
            if (obs10() !== exp_obs(lat, int'(vin10), 10, 4)) begin
                n_fail++;
                $display("FAIL sweep_timeline edge %0d: {smp,cen,busy,dac}=%h required %h",
                         lat, obs10(), exp_obs(lat, int'(vin10), 10, 4));
            end
        end
        n_checks++;
        if (lat != 25 || dout10 !== vin10) begin
            n_fail++;
            $display("FAIL sweep_latency: edges=%0d DOUT=%h required 25/%h", lat, dout10, vin10);
        end
        tick();

        launched = 0;
        received = 0;
        cyc      = 0;
        while (received < 200 && cyc < 20000) begin
            ready10 = ($urandom_range(0, 2) != 0);
            start10 = 1'b0;
            if (!busy10 && launched < 200 && $urandom_range(0, 3) != 0) begin
                vin10   = 10'($urandom_range(0, 1023));
                start10 = 1'b1;
                sb.push_back(vin10);
                launched++;
            end
            if (valid10 && ready10) begin
                want = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
                n_checks++;
                if (dout10 !== want) begin
                    n_fail++;
                    $display("FAIL sweep_dout #%0d: DOUT=%h required %h", received, dout10, want);
                end
                $display("sweep: conversion %0d DOUT=%h", received, dout10);
                received++;
            end
            hold = valid10 && !ready10;
            held = dout10;
            tick();
            start10 = 1'b0;
            cyc++;
            if (hold) begin
                n_checks++;
                if (valid10 !== 1'b1 || dout10 !== held) begin
                    n_fail++;
                    $display("FAIL sweep_hold cycle %0d: VALID=%b DOUT=%h required 1/%h",
                             cyc, valid10, dout10, held);
                end
            end
        end
        n_checks++;
        if (received != 200) begin
            n_fail++;
            $display("FAIL sweep_count: results=%0d required 200", received);
        end
        ready10 = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        start8  = 1'b0;
        ready8  = 1'b0;
        vin8    = 8'h00;
        tie_en  = 1'b0;
        tie_val = 1'b0;
        start10 = 1'b0;
        ready10 = 1'b0;
        vin10   = 10'h000;

        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_reset_valid();
        test_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
